counter_cmd_seq: RTL and testbench
==================================

Name: counter_cmd_seq

Overview:
- Command sequencer directly upstream of the up/down counter. Drives the counter's `load`, `updown` and `data` inputs.
- Accepts multi-cycle commands over a valid/ready interface and buffers them in a small FIFO. Each command is expanded into per-cycle counter controls.
- The counter has no enable. To keep it stable while idle, the block reloads a shadow copy of the count.
- The shadow count is exported so the scoreboard can compare it against the counter's `data_out`.

Parameters:
- WIDTH, 8, counter data width (must match the counter).
- DEPTH, 4, command FIFO entries (power of 2, at least 2).
- RPT_W, 4, width of the repeat field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  a command is offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op  in  2  operation code: 00 LOAD, 01 UP, 10 DOWN, 11 PAUSE.
- cmd_data  in  WIDTH  load value; used by LOAD only.
- cmd_rpt  in  RPT_W  the command executes for cmd_rpt+1 cycles.
- load  out  WIDTH-independent 1  counter load control, registered.
- updown  out  1  counter direction (1 = up), registered.
- data  out  WIDTH  counter load data, registered.
- busy  out  1  high while in EXEC.
- fifo_level  out  $clog2(DEPTH)+1  number of occupied FIFO entries.
- exp_count  out  WIDTH  value the counter holds after the most recent edge.

Behaviour:
- Reset (rst=0, asynchronous):
  - load=1, updown=0, data=0.
  - shadow/exp_count=0, busy=0.
  - FIFO emptied, fifo_level=0, rpt_cnt=0.
  - After release, cmd_ready=1.
- Push: occurs on an edge where cmd_valid && cmd_ready. Command {op, data, rpt} is written to the FIFO.
- cmd_ready is !full only; there is no bypass. When the FIFO is full, a pop on the same edge does not let a push in.
- Registered outputs are presented during cycle k; the counter acts on them at edge k+1. shadow updates on that same edge using the same rule as the counter:
  - if load: shadow = data;
  - else if updown: shadow = shadow+1;
  - else: shadow = shadow-1.
  - All arithmetic is modulo 2^WIDTH: 0xFF+1 = 0x00, 0x00-1 = 0xFF.
- State machine, IDLE and EXEC:
  - IDLE, FIFO empty: drive load=1, data=shadow_next (hold), busy=0.
  - IDLE, FIFO non-empty at an edge: pop the head and go to EXEC. On that edge, set rpt_cnt=rpt and register the outputs per op.
  - EXEC: outputs per op, held for rpt_cnt+1 cycles. rpt_cnt decrements each edge.
  - EXEC with rpt_cnt==0 at an edge, FIFO non-empty: pop the next command with no bubble cycle.
  - EXEC with rpt_cnt==0 at an edge, FIFO empty: go to IDLE with hold outputs.
- Op encodings:
  - LOAD: load=1, data=cmd_data, every repeat cycle.
  - UP: load=0, updown=1.
  - DOWN: load=0, updown=0.
  - PAUSE: load=1, data=current shadow_next (the count holds).
- Latency: a command pushed at edge T into an empty FIFO while IDLE is popped at edge T+1. Its first effect on the counter and exp_count is at edge T+2.
- fifo_level: +1 on push, -1 on pop, unchanged when both occur on the same edge.
- Reset asserted mid-command: in-flight and queued commands are discarded immediately; the block restarts in IDLE with shadow=0.
- Interface rule: cmd_op, cmd_data and cmd_rpt must be stable while cmd_valid=1 && cmd_ready=0. The bench asserts this.

Test Plan:
- Reset, then IDLE for 10 cycles -> load=1, data=0; counter and exp_count stay 0x00; busy=0; cmd_ready=1.
- Push LOAD data=0x05 rpt=0, then UP rpt=2 (back-to-back) -> exp_count sequence 0x05, 0x06, 0x07, 0x08, then holds at 0x08; counter data_out matches every cycle; no idle cycle between the two commands.
- Push LOAD 0xFE rpt=0, UP rpt=3 -> 0xFE, 0xFF, 0x00, 0x01, 0x02. Then DOWN rpt=3 -> 0x01, 0x00, 0xFF, 0xFE (both wrap-arounds).
- Hold cmd_valid=1 while pushing 6 commands of UP rpt=15 with DEPTH=4 -> cmd_ready falls when fifo_level=4; no push is accepted while full; all 6 commands execute in order; final exp_count = 96 (0x60).
- PAUSE rpt=4 after reaching 0x33 -> count stays 0x33 for 5 cycles with busy=1, then IDLE.
- Assert rst low mid-way through an UP rpt=15 with 2 commands queued -> outputs return to reset values immediately; fifo_level=0; after release exp_count=0 and no stale command executes.

Source files
------------

// File: rtl/counter_cmd_seq.sv
// Command sequencer feeding an up/down counter: buffers multi-cycle commands in a
// small FIFO and expands each into registered per-cycle load/updown/data controls.
module counter_cmd_seq #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int RPT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_data,
    input  logic [RPT_W-1:0]         cmd_rpt,
    output logic                     load,
    output logic                     updown,
    output logic [WIDTH-1:0]         data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [WIDTH-1:0]         exp_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_UP    = 2'b01,
        OP_DOWN  = 2'b10,
        OP_PAUSE = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_e;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] data;
        logic [RPT_W-1:0] rpt;
    } cmd_t;

    cmd_t             r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    state_e           r_state;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic             r_load;
    logic             r_updown;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_shadow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    cmd_t             w_cmd_in;
    cmd_t             w_head;
    logic [WIDTH-1:0] w_shadow_next;

    assign w_full   = (r_level == LW'(DEPTH));
    assign w_empty  = (r_level == '0);
    // No bypass: a pop on a full edge does not make room for a push on that same edge.
    assign w_push   = cmd_valid && !w_full;
    assign w_pop    = !w_empty && ((r_state == S_IDLE) || (r_rpt_cnt == '0));
    assign w_cmd_in = cmd_t'({cmd_op, cmd_data, cmd_rpt});
    assign w_head   = r_mem[r_rd_ptr];

    // Same rule the counter applies to the outputs it sees this cycle.
    assign w_shadow_next = r_load   ? r_data :
                           r_updown ? r_shadow + WIDTH'(1) :
                                      r_shadow - WIDTH'(1);

    // NOTE: FIFO storage has no reset; the pointers and level alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_rpt_cnt <= '0;
            r_load    <= 1'b1;
            r_updown  <= 1'b0;
            r_data    <= '0;
            r_shadow  <= '0;
        end else begin
            r_shadow <= w_shadow_next;
            if (w_pop) begin
                r_state   <= S_EXEC;
                r_rpt_cnt <= w_head.rpt;
                case (w_head.op)
                    OP_LOAD: begin
                        r_load   <= 1'b1;
                        r_updown <= 1'b0;
                        r_data   <= w_head.data;
                    end
                    OP_UP: begin
                        r_load   <= 1'b0;
                        r_updown <= 1'b1;
                    end
                    OP_DOWN: begin
                        r_load   <= 1'b0;
                        r_updown <= 1'b0;
                    end
                    OP_PAUSE: begin
                        r_load   <= 1'b1;
                        r_updown <= 1'b0;
                        r_data   <= w_shadow_next;
                    end
                endcase
            end else if ((r_state == S_EXEC) && (r_rpt_cnt != '0)) begin
                // Outputs simply hold; a held PAUSE/LOAD keeps reloading the same value.
                r_rpt_cnt <= r_rpt_cnt - RPT_W'(1);
            end else begin
                // Idle: the counter has no enable, so keep reloading the current count.
                r_state  <= S_IDLE;
                r_load   <= 1'b1;
                r_updown <= 1'b0;
                r_data   <= w_shadow_next;
            end
        end
    end

    assign cmd_ready  = !w_full;
    assign load       = r_load;
    assign updown     = r_updown;
    assign data       = r_data;
    assign busy       = (r_state == S_EXEC);
    assign fifo_level = r_level;
    assign exp_count  = r_shadow;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Bench for counter_cmd_seq: a schedule-based model predicts, per accepted command,
// the edge and value of every counter step; a negedge monitor compares against the DUT.
module tb_counter_cmd_seq;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int RPT_W = 4;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_PAUSE = 2'b11;

    typedef struct {
        int         e;
        logic [7:0] v;
    } exp_t;

    typedef struct {
        int push_e;
        int pop_e;
    } pop_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic [1:0]            cmd_op = '0;
    logic [WIDTH-1:0]      cmd_data = '0;
    logic [RPT_W-1:0]      cmd_rpt = '0;
    logic                  load;
    logic                  updown;
    logic [WIDTH-1:0]      data;
    logic                  busy;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [WIDTH-1:0]      exp_count;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;

    exp_t       exp_q[$];
    pop_t       pop_q[$];
    logic [7:0] model_count = 8'h00;
    int         free_edge = 0;
    logic [7:0] mon_last = 8'h00;
    int         mon_lvl;
    logic       saw_full = 1'b0;
    logic       stall_prev = 1'b0;
    logic [13:0] stall_vals = '0;
    logic [7:0] cnt_out;

    counter_cmd_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RPT_W(RPT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_rpt    (cmd_rpt),
        .load       (load),
        .updown     (updown),
        .data       (data),
        .busy       (busy),
        .fifo_level (fifo_level),
        .exp_count  (exp_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream counter driven by the sequencer outputs.
    always @(posedge clk or negedge rst) begin
        if (!rst)        cnt_out <= 8'h00;
        else if (load)   cnt_out <= data;
        else if (updown) cnt_out <= cnt_out + 8'd1;
        else             cnt_out <= cnt_out - 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Command accepted at edge t: popped once eligible and the previous command is done,
    // then one counter step per edge for rpt+1 edges.
    function automatic void model_push(input int t, input logic [1:0] op,
                                       input logic [7:0] d, input logic [3:0] r);
        int p;
        p = (t + 1 > free_edge) ? t + 1 : free_edge;
        pop_q.push_back('{push_e: t, pop_e: p});
        for (int i = 0; i <= int'(r); i++) begin
            case (op)
                OP_LOAD:  model_count = d;
                OP_UP:    model_count = model_count + 8'd1;
                OP_DOWN:  model_count = model_count - 8'd1;
                default:  model_count = model_count;
            endcase
            exp_q.push_back('{e: p + 1 + i, v: model_count});
        end
        free_edge = p + int'(r) + 1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            while (exp_q.size() > 0 && exp_q[0].e < cyc) begin
                fail("missed_step");
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].e == cyc) begin
                mon_last = exp_q[0].v;
                void'(exp_q.pop_front());
            end
            check("exp_count", 32'(exp_count), 32'(mon_last));
            check("counter_vs_exp", 32'(cnt_out), 32'(exp_count));
            check("busy", 32'(busy), 32'(exp_q.size() > 0 && exp_q[0].e == cyc + 1));
            while (pop_q.size() > 0 && pop_q[0].pop_e <= cyc) void'(pop_q.pop_front());
            mon_lvl = 0;
            foreach (pop_q[i]) if (pop_q[i].push_e <= cyc) mon_lvl++;
            check("fifo_level", 32'(fifo_level), 32'(mon_lvl));
            check("cmd_ready", 32'(cmd_ready), 32'(mon_lvl < DEPTH));
            if (fifo_level == 4) saw_full = 1'b1;
            if (stall_prev && cmd_valid)
                check("cmd_stable", 32'({cmd_op, cmd_data, cmd_rpt}), 32'(stall_vals));
            stall_prev = cmd_valid && !cmd_ready;
            stall_vals = {cmd_op, cmd_data, cmd_rpt};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] d, input logic [3:0] r);
        int  waited = 0;
        bit  done = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_rpt   = r;
        while (!done) begin
            @(negedge clk);
            if (cmd_ready) begin
                model_push(cyc + 1, op, d, r);
                done = 1;
            end else if (++waited > 300) begin
                fail("send_timeout");
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int g = 0;
        while ((exp_q.size() != 0 || busy) && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 2000) fail("drain_timeout");
        idle(2);
    endtask

    // Called just after a posedge; reset lands mid-cycle, outputs must drop at once.
    task automatic reset_mid();
        cmd_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_load", 32'(load), 32'd1);
        check("rst_updown", 32'(updown), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_exp_count", 32'(exp_count), 32'd0);
        exp_q.delete();
        pop_q.delete();
        model_count = 8'h00;
        free_edge   = 0;
        mon_last    = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Idle after reset: the count is held by reloading zero.
        idle(10);
        check("idle_load", 32'(load), 32'd1);
        check("idle_data", 32'(data), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(cmd_ready), 32'd1);
        check("idle_count", 32'(cnt_out), 32'd0);

        send(OP_LOAD, 8'h05, 4'd0);
        send(OP_UP, 8'h00, 4'd2);
        wait_done();
        check("load_up_final", 32'(exp_count), 32'h08);

        send(OP_LOAD, 8'hFE, 4'd0);
        send(OP_UP, 8'h00, 4'd3);
        wait_done();
        check("wrap_up_final", 32'(exp_count), 32'h02);
        send(OP_DOWN, 8'h00, 4'd3);
        wait_done();
        check("wrap_down_final", 32'(exp_count), 32'hFE);

        reset_mid();
        saw_full = 1'b0;
        for (int i = 0; i < 6; i++) send(OP_UP, 8'h00, 4'd15);
        wait_done();
        check("full_final", 32'(exp_count), 32'h60);
        check("full_seen", 32'(saw_full), 32'd1);

        send(OP_LOAD, 8'h33, 4'd0);
        send(OP_PAUSE, 8'h00, 4'd4);
        wait_done();
        check("pause_final", 32'(exp_count), 32'h33);
        check("pause_idle", 32'(busy), 32'd0);

        send(OP_UP, 8'h00, 4'd15);
        send(OP_UP, 8'h00, 4'd15);
        send(OP_DOWN, 8'h00, 4'd15);
        idle(3);
        reset_mid();
        idle(30);
        check("post_rst_count", 32'(exp_count), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_level", 32'(fifo_level), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [7:0] d;
            logic [3:0] r;
            op = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            r  = 4'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
            send(op, d, r);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        wait_done();
        check("random_final", 32'(exp_count), 32'(model_count));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
